// File: rtl/eprom_programmer.sv
// eprom_programmer: erases a small parallel device, checks it reads blank,
// programs it from a valid/ready byte stream and verifies it by comparing a
// write-side checksum against a read-back checksum.
module eprom_programmer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_erase,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERASE  = 3'd1;
  localparam logic [2:0] S_BLANK  = 3'd2;
  localparam logic [2:0] S_PROG   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_VERIFY = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_BLANK  = 2'b01;
  localparam logic [1:0] ERR_VERIFY = 2'b10;

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] sum_w;
  logic [DATA_W-1:0] sum_r;

  // Depth is a power of two, so the last address is all ones and cnt+1
  // wraps back to zero on its own.
  logic              last_addr;
  logic              blank_ok;
  logic [DATA_W-1:0] sum_r_next;

  assign last_addr  = (cnt == {ADDR_W{1'b1}});
  assign blank_ok   = (mem_data == {DATA_W{1'b1}});
  assign sum_r_next = sum_r + mem_data;

  // Strobes are pure decodes of the state register, so an asynchronous
  // reset clears them in the same instant it forces IDLE.
  assign in_ready  = (state == S_PROG);
  assign mem_we    = (state == S_WRITE);
  assign mem_erase = (state == S_ERASE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_addr  = cnt;
  assign mem_din   = wdata;

  // Sequencer: state, address counter, checksums and run status.
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of their neighbours; blocking assignments would make the result depend
  // on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wdata    <= '0;
      sum_w    <= '0;
      sum_r    <= '0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ERASE;
            cnt      <= '0;
            sum_w    <= '0;
            sum_r    <= '0;
            err_code <= ERR_NONE;
            err_addr <= '0;
          end
        end
        S_ERASE: begin
          state <= S_BLANK;
          cnt   <= '0;
        end
        S_BLANK: begin
          if (!blank_ok) begin
            err_code <= ERR_BLANK;
            err_addr <= cnt;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (last_addr) state <= S_PROG;
          end
        end
        S_PROG: begin
          if (in_valid) begin
            wdata <= in_data;
            sum_w <= sum_w + in_data;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt   <= cnt + 1'b1;
          state <= last_addr ? S_VERIFY : S_PROG;
        end
        S_VERIFY: begin
          sum_r <= sum_r_next;
          cnt   <= cnt + 1'b1;
          if (last_addr) begin
            if (sum_r_next != sum_w) err_code <= ERR_VERIFY;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
